control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clock  in  1  system clock, rising-edge active.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: opcode  in  7  Instruction[6:0] from the instruction register.
REQ-004 SHALL have port: funct3  in  3  Instruction[14:12].
REQ-005 SHALL have port: funct7  in  7  Instruction[31:25].
REQ-006 SHALL have ports: igual_Ula, menor_Ula, overFlow_Ula  in  1 each  ALU flags.
REQ-007 SHALL have port: Estado  out  5  current state code.
REQ-008 SHALL have ports: Ld_ir, pc_wr, reg_wr, memoria_wr, ld_a, ld_b, ld_aluout, ld_mdr, epc_wr, causa_wr  out  1 each  register and memory write enables.
REQ-009 SHALL have ports: mux_a_sel  out  2; mux_b_sel  out  3; mux_reg_sel  out  2; pc_src  out  2; ula_op  out  3  datapath selects.
REQ-010 SHALL have port: causa_val  out  64  cause code (0 = invalid opcode, 1 = overflow).

Function
REQ-011 SHALL be a Moore FSM; every output SHALL be a function of the state register only.
REQ-012 State codes: RESET=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXEC_R=4, EXEC_I=5, ADDR=6, LD_WAIT=7, LD_WB=8, ST_MEM=9, BRANCH=10, JAL=11, JALR=12, LUI=13, WB_ALU=14, EXC_OP=15, EXC_OVF=16, EXC_VEC=17, HALT=18.
REQ-013 FETCH SHALL drive memory read at PC, pc_wr=1 with PC+4, and go to FETCH_WAIT.
REQ-014 FETCH_WAIT SHALL assert Ld_ir=1 (one cycle of memory latency) and go to DECODE.
REQ-015 DECODE SHALL assert ld_a and ld_b, and compute PC+imm into ALUOut.
REQ-016 DECODE SHALL dispatch on opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> ADDR; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 1110011 -> HALT; any other value -> EXC_OP.
REQ-017 EXEC_R: funct7=0100000 SHALL select subtract; otherwise add, and/or/xor by funct3.
REQ-018 EXEC_R and EXEC_I SHALL assert ld_aluout and go to WB_ALU; when overFlow_Ula=1 they SHALL go to EXC_OVF instead, and no register write SHALL occur.
REQ-019 ADDR SHALL compute A+imm and then go to LD_WAIT (load) or ST_MEM (store).
REQ-020 LD_WAIT SHALL assert ld_mdr and go to LD_WB.
REQ-021 LD_WB SHALL assert reg_wr=1 with mux_reg_sel=MDR and go to FETCH.
REQ-022 ST_MEM SHALL assert memoria_wr=1 for exactly one cycle and go to FETCH.
REQ-023 BRANCH SHALL compare A with B and assert pc_wr=1 with pc_src=ALUOut when taken.
REQ-024 Branch taken conditions: funct3 000 beq -> igual; 001 bne -> !igual; 100 blt -> menor; 101 bge -> !menor. Other funct3 values SHALL never be taken. BRANCH SHALL then go to FETCH.
REQ-025 JAL and JALR SHALL write PC (return address, already PC+4) to rd with reg_wr=1 and load the target into PC in the same cycle, then go to FETCH.
REQ-026 LUI SHALL write imm to rd and go to FETCH.
REQ-027 EXC_OP and EXC_OVF SHALL each last one cycle and assert epc_wr=1 (EPC <= PC-4, computed by ALU) and causa_wr=1 with causa_val = 0 or 1 respectively.
REQ-028 EXC_VEC SHALL load PC from the vector (pc_src=VECTOR: 255 for opcode, 254 for overflow, held by the datapath) and go to FETCH.
REQ-029 HALT SHALL be absorbing; all enables SHALL be 0 until reset.
REQ-030 Write enables SHALL never be asserted in two consecutive states except as listed; memoria_wr and reg_wr SHALL never be asserted together.

Reset
REQ-031 Reset SHALL force state RESET asynchronously; all enables SHALL be 0, all selects 0, causa_val 0, Estado=0.
REQ-032 RESET SHALL transition to FETCH on the first clock edge after reset deasserts.
REQ-033 Reset asserted mid-instruction (for example in ST_MEM) SHALL abort the instruction immediately, with no further writes.

Structure
REQ-034 State enum, opcode constants, ula_op codes and mux select encodings SHALL reside in shared package cpu_pkg.
REQ-035 Combinational decode (opcode/funct -> ula_op, branch condition) SHALL be the sub-module alu_decoder; next-state and output logic stay in control_unit.

Verification
REQ-036 Reset for 3 cycles, then release -> Estado 0,1,2,3 on successive edges; Ld_ir=1 only in state 2.
REQ-037 opcode=0110011, funct7=0100000, overFlow_Ula=0 -> states 3,4,14; reg_wr=1 exactly in state 14; ula_op=SUB in state 4.
REQ-038 opcode=0000011 -> states 3,6,7,8,1; ld_mdr in state 7; reg_wr with mux_reg_sel=MDR in state 8.
REQ-039 opcode=1100011, funct3=001, igual_Ula=0 -> pc_wr=1 in state 10; with igual_Ula=1 -> pc_wr=0.
REQ-040 opcode=0000000 -> states 15,17,1; causa_val=0 with epc_wr=causa_wr=1 in state 15. Overflow in EXEC_I -> state 16, causa_val=1, reg_wr never asserted.
REQ-041 Reset pulse during ST_MEM -> memoria_wr drops in the same cycle; Estado=0 before the next clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle control path:
// FSM state codes, opcodes, ALU operations and datapath selects.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_EXEC_R     = 5'd4,
    S_EXEC_I     = 5'd5,
    S_ADDR       = 5'd6,
    S_LD_WAIT    = 5'd7,
    S_LD_WB      = 5'd8,
    S_ST_MEM     = 5'd9,
    S_BRANCH     = 5'd10,
    S_JAL        = 5'd11,
    S_JALR       = 5'd12,
    S_LUI        = 5'd13,
    S_WB_ALU     = 5'd14,
    S_EXC_OP     = 5'd15,
    S_EXC_OVF    = 5'd16,
    S_EXC_VEC    = 5'd17,
    S_HALT       = 5'd18
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [2:0] ULA_ADD = 3'd0;
  localparam logic [2:0] ULA_SUB = 3'd1;
  localparam logic [2:0] ULA_AND = 3'd2;
  localparam logic [2:0] ULA_OR  = 3'd3;
  localparam logic [2:0] ULA_XOR = 3'd4;

  localparam logic [1:0] MA_PC = 2'd0;
  localparam logic [1:0] MA_A  = 2'd1;

  localparam logic [2:0] MB_B    = 3'd0;
  localparam logic [2:0] MB_FOUR = 3'd1;
  localparam logic [2:0] MB_IMM  = 3'd2;

  localparam logic [1:0] MR_ALUOUT = 2'd0;
  localparam logic [1:0] MR_MDR    = 2'd1;
  localparam logic [1:0] MR_PC     = 2'd2;
  localparam logic [1:0] MR_IMM    = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_VECTOR = 2'd2;

  localparam logic [63:0] CAUSE_OPCODE = 64'd0;
  localparam logic [63:0] CAUSE_OVF    = 64'd1;

endpackage

// File: rtl/control_unit_alu_decoder.sv
// Instruction-field decode: ALU operation from opcode/funct
// and branch-taken resolution from the ALU flags.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       igual_i,
  input  logic       menor_i,
  output logic [2:0] ula_op_o,
  output logic       br_taken_o
);

  logic is_sub;

  assign is_sub = (opcode_i == OP_R) && (funct7_i == F7_ALT);

  always_comb begin
    ula_op_o = ULA_ADD;
    unique case (1'b1)
      is_sub:               ula_op_o = ULA_SUB;
      (funct3_i == F3_AND): ula_op_o = ULA_AND;
      (funct3_i == F3_OR):  ula_op_o = ULA_OR;
      (funct3_i == F3_XOR): ula_op_o = ULA_XOR;
      default:              ula_op_o = ULA_ADD;
    endcase
  end

  always_comb begin
    br_taken_o = 1'b0;
    unique case (1'b1)
      (funct3_i == F3_BEQ): br_taken_o = igual_i;
      (funct3_i == F3_BNE): br_taken_o = !igual_i;
      (funct3_i == F3_BLT): br_taken_o = menor_i;
      (funct3_i == F3_BGE): br_taken_o = !menor_i;
      default:              br_taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute
// and exception entry for the datapath.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        igual_Ula,
  input  logic        menor_Ula,
  input  logic        overFlow_Ula,
  output logic [4:0]  Estado,
  output logic        Ld_ir,
  output logic        pc_wr,
  output logic        reg_wr,
  output logic        memoria_wr,
  output logic        ld_a,
  output logic        ld_b,
  output logic        ld_aluout,
  output logic        ld_mdr,
  output logic        epc_wr,
  output logic        causa_wr,
  output logic [1:0]  mux_a_sel,
  output logic [2:0]  mux_b_sel,
  output logic [1:0]  mux_reg_sel,
  output logic [1:0]  pc_src,
  output logic [2:0]  ula_op,
  output logic [63:0] causa_val
);

  state_e     state_q, state_d;
  logic [2:0] dec_op;
  logic       br_taken;

  alu_decoder u_alu_decoder (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .igual_i    (igual_Ula),
    .menor_i    (menor_Ula),
    .ula_op_o   (dec_op),
    .br_taken_o (br_taken)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  assign Estado = state_q;

  // Only the instruction register and the ALU flags of the
  // current compare qualify outputs; all else is per-state.
  always_comb begin
    state_d     = state_q;
    Ld_ir       = 1'b0;
    pc_wr       = 1'b0;
    reg_wr      = 1'b0;
    memoria_wr  = 1'b0;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_aluout   = 1'b0;
    ld_mdr      = 1'b0;
    epc_wr      = 1'b0;
    causa_wr    = 1'b0;
    mux_a_sel   = MA_PC;
    mux_b_sel   = MB_B;
    mux_reg_sel = MR_ALUOUT;
    pc_src      = PC_ALU;
    ula_op      = ULA_ADD;
    causa_val   = CAUSE_OPCODE;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        pc_wr     = 1'b1;
        mux_b_sel = MB_FOUR;
        state_d   = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        Ld_ir   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ld_a      = 1'b1;
        ld_b      = 1'b1;
        ld_aluout = 1'b1;
        mux_b_sel = MB_IMM;
        unique case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_SYSTEM:         state_d = S_HALT;
          default:           state_d = S_EXC_OP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        ld_aluout = 1'b1;
        mux_a_sel = MA_A;
        mux_b_sel = (state_q == S_EXEC_I) ? MB_IMM : MB_B;
        ula_op    = dec_op;
        state_d   = overFlow_Ula ? S_EXC_OVF : S_WB_ALU;
      end
      S_ADDR: begin
        ld_aluout = 1'b1;
        mux_a_sel = MA_A;
        mux_b_sel = MB_IMM;
        state_d   = (opcode == OP_LOAD) ? S_LD_WAIT : S_ST_MEM;
      end
      S_LD_WAIT: begin
        ld_mdr  = 1'b1;
        state_d = S_LD_WB;
      end
      S_LD_WB: begin
        reg_wr      = 1'b1;
        mux_reg_sel = MR_MDR;
        state_d     = S_FETCH;
      end
      S_ST_MEM: begin
        memoria_wr = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        mux_a_sel = MA_A;
        ula_op    = ULA_SUB;
        pc_src    = PC_ALUOUT;
        pc_wr     = br_taken;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        reg_wr      = 1'b1;
        pc_wr       = 1'b1;
        mux_reg_sel = MR_PC;
        pc_src      = PC_ALUOUT;
        state_d     = S_FETCH;
      end
      S_JALR: begin
        reg_wr      = 1'b1;
        pc_wr       = 1'b1;
        mux_reg_sel = MR_PC;
        mux_a_sel   = MA_A;
        mux_b_sel   = MB_IMM;
        state_d     = S_FETCH;
      end
      S_LUI: begin
        reg_wr      = 1'b1;
        mux_reg_sel = MR_IMM;
        state_d     = S_FETCH;
      end
      S_WB_ALU: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXC_OP, S_EXC_OVF: begin
        epc_wr    = 1'b1;
        causa_wr  = 1'b1;
        mux_b_sel = MB_FOUR;
        ula_op    = ULA_SUB;
        causa_val = (state_q == S_EXC_OVF) ? CAUSE_OVF
                                           : CAUSE_OPCODE;
        state_d   = S_EXC_VEC;
      end
      S_EXC_VEC: begin
        pc_wr   = 1'b1;
        pc_src  = PC_VECTOR;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        igual_Ula, menor_Ula, overFlow_Ula;
  logic [4:0]  Estado;
  logic        Ld_ir, pc_wr, reg_wr, memoria_wr;
  logic        ld_a, ld_b, ld_aluout, ld_mdr;
  logic        epc_wr, causa_wr;
  logic [1:0]  mux_a_sel;
  logic [2:0]  mux_b_sel;
  logic [1:0]  mux_reg_sel;
  logic [1:0]  pc_src;
  logic [2:0]  ula_op;
  logic [63:0] causa_val;

  control_unit dut (
    .clock(clock), .reset(reset),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .igual_Ula(igual_Ula), .menor_Ula(menor_Ula),
    .overFlow_Ula(overFlow_Ula),
    .Estado(Estado), .Ld_ir(Ld_ir), .pc_wr(pc_wr),
    .reg_wr(reg_wr), .memoria_wr(memoria_wr),
    .ld_a(ld_a), .ld_b(ld_b), .ld_aluout(ld_aluout),
    .ld_mdr(ld_mdr), .epc_wr(epc_wr), .causa_wr(causa_wr),
    .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel),
    .mux_reg_sel(mux_reg_sel), .pc_src(pc_src),
    .ula_op(ula_op), .causa_val(causa_val)
  );

  always #5 clock = ~clock;

  // {Ld_ir,pc_wr,reg_wr,memoria_wr,ld_a,ld_b,ld_aluout,
  //  ld_mdr,epc_wr,causa_wr}
  logic [9:0] en_w;
  assign en_w = {Ld_ir, pc_wr, reg_wr, memoria_wr, ld_a, ld_b,
                 ld_aluout, ld_mdr, epc_wr, causa_wr};

  typedef struct {
    string       nm;
    logic [4:0]  st;
    logic [9:0]  en;
    logic [2:0]  ula;
    logic [1:0]  mrs;
    logic [1:0]  pcs;
    logic [63:0] cv;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  event probe_e;

  always begin
    @(negedge clock or probe_e);
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (Estado !== e.st || en_w !== e.en || ula_op !== e.ula ||
          mux_reg_sel !== e.mrs || pc_src !== e.pcs ||
          causa_val !== e.cv) begin
        failures++;
        $display("FAIL %s: got st=%0d en=%b ula=%0d mrs=%0d pcs=%0d cv=%0d want st=%0d en=%b ula=%0d mrs=%0d pcs=%0d cv=%0d",
                 e.nm, Estado, en_w, ula_op, mux_reg_sel, pc_src,
                 causa_val, e.st, e.en, e.ula, e.mrs, e.pcs, e.cv);
      end
      checks++;
      if (memoria_wr === 1'b1 && reg_wr === 1'b1) begin
        failures++;
        $display("FAIL %s_mem_reg_excl: got both=1 want not both",
                 e.nm);
      end
    end
  end

  task automatic push(input string nm, input logic [4:0] st,
                      input logic [9:0] en,
                      input logic [2:0] ula = 3'd0,
                      input logic [1:0] mrs = 2'd0,
                      input logic [1:0] pcs = 2'd0,
                      input logic [63:0] cv = 64'd0);
    exp_t x;
    x.nm = nm; x.st = st; x.en = en; x.ula = ula;
    x.mrs = mrs; x.pcs = pcs; x.cv = cv;
    q.push_back(x);
  endtask

  task automatic cyc(input string nm, input logic [4:0] st,
                     input logic [9:0] en,
                     input logic [2:0] ula = 3'd0,
                     input logic [1:0] mrs = 2'd0,
                     input logic [1:0] pcs = 2'd0,
                     input logic [63:0] cv = 64'd0);
    push(nm, st, en, ula, mrs, pcs, cv);
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
    cyc("fetch",  5'd1, 10'h100);
    cyc("fwait",  5'd2, 10'h200);
    cyc("decode", 5'd3, 10'h038);
  endtask

  task automatic branch(input string nm, input logic [2:0] f3,
                        input logic ig, input logic mn,
                        input logic taken);
    igual_Ula = ig; menor_Ula = mn;
    instr(7'b1100011, f3, 7'd0);
    cyc(nm, 5'd10, taken ? 10'h100 : 10'h000, 3'd1, 2'd0, 2'd1);
  endtask

  initial begin
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    igual_Ula = 1'b0; menor_Ula = 1'b0; overFlow_Ula = 1'b0;
    #1 reset = 1'b1;
    @(posedge clock); #1;
    repeat (3) cyc("rst_hold", 5'd0, 10'h000);
    reset = 1'b0;
    cyc("rst_rel", 5'd0, 10'h000);

    instr(7'b0110011, 3'b000, 7'b0100000);
    cyc("exec_r_sub", 5'd4, 10'h008, 3'd1);
    cyc("wb_sub", 5'd14, 10'h080);

    instr(7'b0110011, 3'b111, 7'b0000000);
    cyc("exec_r_and", 5'd4, 10'h008, 3'd2);
    cyc("wb_and", 5'd14, 10'h080);

    instr(7'b0000011, 3'b010, 7'd0);
    cyc("ld_addr", 5'd6, 10'h008);
    cyc("ld_wait", 5'd7, 10'h004);
    cyc("ld_wb", 5'd8, 10'h080, 3'd0, 2'd1);

    branch("bne_taken",  3'b001, 1'b0, 1'b0, 1'b1);
    branch("bne_not",    3'b001, 1'b1, 1'b0, 1'b0);
    branch("beq_taken",  3'b000, 1'b1, 1'b0, 1'b1);
    branch("blt_taken",  3'b100, 1'b0, 1'b1, 1'b1);
    branch("bge_not",    3'b101, 1'b0, 1'b1, 1'b0);
    branch("f3_010_not", 3'b010, 1'b1, 1'b1, 1'b0);
    igual_Ula = 1'b0; menor_Ula = 1'b0;

    instr(7'b0000000, 3'd0, 7'd0);
    cyc("exc_op", 5'd15, 10'h003, 3'd1, 2'd0, 2'd0, 64'd0);
    cyc("exc_vec_op", 5'd17, 10'h100, 3'd0, 2'd0, 2'd2);

    overFlow_Ula = 1'b1;
    instr(7'b0010011, 3'b000, 7'd0);
    cyc("exec_i_ovf", 5'd5, 10'h008, 3'd0);
    cyc("exc_ovf", 5'd16, 10'h003, 3'd1, 2'd0, 2'd0, 64'd1);
    cyc("exc_vec_ovf", 5'd17, 10'h100, 3'd0, 2'd0, 2'd2);
    overFlow_Ula = 1'b0;

    instr(7'b0010011, 3'b100, 7'b0100000);
    cyc("exec_i_xor", 5'd5, 10'h008, 3'd4);
    cyc("wb_xor", 5'd14, 10'h080);

    instr(7'b1101111, 3'd0, 7'd0);
    cyc("jal", 5'd11, 10'h180, 3'd0, 2'd2, 2'd1);
    instr(7'b1100111, 3'd0, 7'd0);
    cyc("jalr", 5'd12, 10'h180, 3'd0, 2'd2, 2'd0);
    instr(7'b0110111, 3'd0, 7'd0);
    cyc("lui", 5'd13, 10'h080, 3'd0, 2'd3);

    instr(7'b0100011, 3'b010, 7'd0);
    cyc("st_addr", 5'd6, 10'h008);
    cyc("st_mem", 5'd9, 10'h040);

    instr(7'b0100011, 3'b010, 7'd0);
    cyc("st_addr2", 5'd6, 10'h008);
    push("st_mem_pre_rst", 5'd9, 10'h040);
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    push("st_mem_abort", 5'd0, 10'h000);
    -> probe_e;
    @(posedge clock); #1;
    repeat (2) cyc("rst_hold2", 5'd0, 10'h000);
    reset = 1'b0;
    cyc("rst_rel2", 5'd0, 10'h000);

    instr(7'b1110011, 3'd0, 7'd0);
    opcode = 7'b0110011;
    repeat (3) cyc("halt", 5'd18, 10'h000);

    reset = 1'b1;
    cyc("rst_halt", 5'd0, 10'h000);
    reset = 1'b0;
    cyc("rst_rel3", 5'd0, 10'h000);
    cyc("fetch_after", 5'd1, 10'h100);

    @(negedge clock); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
